wb_regfile_sb: RTL and testbench
================================

// Module: wb_regfile_sb
// PURPOSE
//  Parametrised writeback register file for the R/F/M register groups, with an integrated write scoreboard.
//  Sits between the ME/WB commit point and EX operand fetch:
//   - accepts commits through a valid/ready handshake;
//   - tracks registers that have an issued but not yet committed write (busy);
//   - serves NRD combinational read ports.
//  After reset, a sweep FSM clears all banks before the block accepts traffic.
// PARAMETERS
//  XLEN  32   width of the R and F registers
//  MLEN  512  width of the M (matrix) registers
//  NREG  32   registers per group; IDXW = $clog2(NREG)
//  NRD   3    number of read ports (rs1..rsNRD)
// PORTS
//  clk           in   1         clock
//  rst           in   1         reset, asynchronous, active-low
//  wb_valid      in   1         commit request
//  wb_ready      out  1         commit accepted when wb_valid & wb_ready
//  wb_group      in   2         destination group (R=00, F=01, M=10, 11=reserved)
//  wb_index      in   IDXW      destination index
//  wb_data_r     in   XLEN      data for group R
//  wb_data_f     in   XLEN      data for group F
//  wb_data_m     in   MLEN      data for group M
//  iss_valid     in   1         issue request from ID/EX
//  iss_ready     out  1         issue accepted when iss_valid & iss_ready
//  iss_we        in   1         issued instruction writes a destination register
//  iss_group     in   2         destination group of the issued instruction
//  iss_index     in   IDXW      destination index of the issued instruction
//  rs_group      in   2*NRD     source groups, packed
//  rs_index      in   IDXW*NRD  source indices, packed
//  rs_busy       out  NRD       source has a pending write
//  dout_r        out  XLEN*NRD  R read data per port
//  dout_f        out  XLEN*NRD  F read data per port
//  dout_m        out  MLEN*NRD  M read data per port
//  init_done     out  1         bank clear sweep has finished
//  sb_err        out  1         sticky: commit to a register that was not busy
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=INIT, sweep counter=0, all busy bits=0;
//   - wb_ready=0, iss_ready=0, init_done=0, sb_err=0.
//  INIT state:
//   - each cycle clears R/F/M[cnt] to 0 and increments cnt;
//   - when cnt==NREG-1, the next state is RUN and init_done=1 (NREG cycles in total);
//   - valid requests are ignored in INIT; inputs are not sampled.
//  RUN state:
//   - wb_ready=1 permanently;
//   - a commit writes the selected bank at the posedge and clears busy[group][index];
//   - write latency 1 cycle; read data is combinational from the array.
//  Special registers and groups:
//   - R x0: writes are dropped, never marked busy, always reads 0;
//   - group 11: commit is accepted and dropped; reads return 0, rs_busy=0.
//  Issue:
//   - iss_ready = RUN & ~(iss_we & busy[target] & ~clr_same), where clr_same = commit to the same target this cycle (WAW stall);
//   - accepted issue with iss_we=1 sets busy[target], except R x0 and group 11;
//   - set and clear of the same target in one cycle: set wins, so the busy bit stays 1.
//  rs_busy[i] = busy[rs_group[i]][rs_index[i]], combinational.
//  sb_err sets on a commit to a non-busy valid target (R x0 excluded); cleared only by reset. The data is still written.
//  Reset mid-sweep or mid-RUN returns to INIT with cnt=0, and all busy state is lost.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//   - a read port whose group and index match a same-cycle commit returns wb_data_*;
//   - that port's rs_busy is forced to 0 (write-to-read forwarding, 0-cycle);
//   - R x0 stays 0.
//  WB_BYPASS_EN undefined: reads see the commit only from the next cycle, and rs_busy stays 1 during the commit cycle.
// STRUCTURE
//  Package wb_pkg:
//   - REG_GROUP_R/F/M/RSV codes;
//   - state enum {INIT, RUN};
//   - helper function for packed port slicing.
//  Sub-module wb_scoreboard:
//   - 3 x NREG busy bits;
//   - set/clear arbitration, iss_ready, rs_busy, sb_err.
//  The top level holds the banks, sweep FSM, read muxes and bypass.
// TESTING
//  - Reset release -> init_done rises after exactly 32 cycles; wb_ready/iss_ready stay 0 until then; all reads return 0.
//  - Issue R5 we=1, then commit R5=0xDEADBEEF -> rs_busy for R5 goes 1 then 0; next cycle dout_r=0xDEADBEEF; sb_err=0.
//  - Issue F3 while F3 busy -> iss_ready=0; same cycle as the commit to F3 -> iss_ready=1 and busy stays 1.
//  - Commit R0=0x1234 -> dout_r=0 on read; commit M7 never issued -> M7 written and sb_err=1 (sticky).
//  - Bypass: read M2 during the commit of M2=all-ones -> with WB_BYPASS_EN dout_m=all-ones in the same cycle; without it, old value.
//  - Assert rst mid-sweep at cnt=10 and in RUN with busy bits set -> state INIT, busy=0, sweep restarts from 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared codes for the writeback register file: register group encodings, sweep FSM states,
// and the lane-offset helper used to slice the packed read-port buses.
package wb_pkg;

  localparam logic [1:0] REG_GROUP_R   = 2'b00;
  localparam logic [1:0] REG_GROUP_F   = 2'b01;
  localparam logic [1:0] REG_GROUP_M   = 2'b10;
  localparam logic [1:0] REG_GROUP_RSV = 2'b11;

  typedef enum logic {INIT, RUN} wb_state_t;

  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for R/F/M: issue sets, commit clears (set wins on collision), WAW stall on iss_ready,
// combinational rs_busy lookup and a sticky error for commits to a target with no pending write.
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter int NREG = 32,
  parameter int NRD  = 3,
  parameter int IDXW = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 wb_fire,
  input  logic [1:0]           wb_group,
  input  logic [IDXW-1:0]      wb_index,
  input  logic                 iss_valid,
  input  logic                 iss_we,
  input  logic [1:0]           iss_group,
  input  logic [IDXW-1:0]      iss_index,
  input  logic [2*NRD-1:0]     rs_group,
  input  logic [IDXW*NRD-1:0]  rs_index,
  output logic                 iss_ready,
  output logic [NRD-1:0]       rs_busy,
  output logic                 sb_err
);

  logic [2:0][NREG-1:0] busy_q, busy_d;
  logic wb_tracked, iss_tracked, wb_busy, iss_busy, clr_same, set_en, clr_en;

  // R x0 and the reserved group never hold a pending write
  assign wb_tracked  = (wb_group != REG_GROUP_RSV) && !(wb_group == REG_GROUP_R && wb_index == '0);
  assign iss_tracked = (iss_group != REG_GROUP_RSV) && !(iss_group == REG_GROUP_R && iss_index == '0);
  assign wb_busy     = wb_tracked && busy_q[wb_group][wb_index];
  assign iss_busy    = iss_tracked && busy_q[iss_group][iss_index];

  assign clr_same  = wb_fire && (wb_group == iss_group) && (wb_index == iss_index);
  assign iss_ready = run && !(iss_we && iss_busy && !clr_same);
  assign set_en    = iss_valid && iss_ready && iss_we && iss_tracked;
  assign clr_en    = wb_fire && wb_tracked;

  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[wb_group][wb_index] = 1'b0;
    if (set_en) busy_d[iss_group][iss_index] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
      sb_err <= 1'b0;
    end else begin
      busy_q <= busy_d;
      if (clr_en && !wb_busy) sb_err <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rs
    logic [1:0]      g;
    logic [IDXW-1:0] i;
    assign g = rs_group[port_lsb(p, 2) +: 2];
    assign i = rs_index[port_lsb(p, IDXW) +: IDXW];
    assign rs_busy[p] = (g != REG_GROUP_RSV) && busy_q[g][i];
  end

endmodule

// File: rtl/wb_regfile_sb.sv
// R/F/M writeback register file with scoreboard; banks are swept to zero for NREG cycles after reset.
// Commit write lands at the next edge, reads are combinational; WB_BYPASS_EN adds same-cycle commit forwarding.
module wb_regfile_sb
  import wb_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int MLEN = 512,
  parameter  int NREG = 32,
  parameter  int NRD  = 3,
  localparam int IDXW = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [1:0]           wb_group,
  input  logic [IDXW-1:0]      wb_index,
  input  logic [XLEN-1:0]      wb_data_r,
  input  logic [XLEN-1:0]      wb_data_f,
  input  logic [MLEN-1:0]      wb_data_m,
  input  logic                 iss_valid,
  output logic                 iss_ready,
  input  logic                 iss_we,
  input  logic [1:0]           iss_group,
  input  logic [IDXW-1:0]      iss_index,
  input  logic [2*NRD-1:0]     rs_group,
  input  logic [IDXW*NRD-1:0]  rs_index,
  output logic [NRD-1:0]       rs_busy,
  output logic [XLEN*NRD-1:0]  dout_r,
  output logic [XLEN*NRD-1:0]  dout_f,
  output logic [MLEN*NRD-1:0]  dout_m,
  output logic                 init_done,
  output logic                 sb_err
);

  wb_state_t       state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic            run, wb_fire;
  logic [NRD-1:0]  sb_busy;

  logic [XLEN-1:0] bank_r [NREG];
  logic [XLEN-1:0] bank_f [NREG];
  logic [MLEN-1:0] bank_m [NREG];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + IDXW'(1);
        if (cnt_q == IDXW'(NREG - 1)) state_d = RUN;
      end
      default: ;
    endcase
  end

  assign run       = (state_q == RUN);
  assign wb_ready  = run;
  assign init_done = run;
  assign wb_fire   = wb_valid && run;

  // Banks carry no reset; the sweep is what makes their contents defined
  always_ff @(posedge clk) begin
    if (!run) begin
      bank_r[cnt_q] <= '0;
      bank_f[cnt_q] <= '0;
      bank_m[cnt_q] <= '0;
    end else if (wb_fire) begin
      case (wb_group)
        REG_GROUP_R: if (wb_index != '0) bank_r[wb_index] <= wb_data_r;
        REG_GROUP_F: bank_f[wb_index] <= wb_data_f;
        REG_GROUP_M: bank_m[wb_index] <= wb_data_m;
        default: ;
      endcase
    end
  end

  wb_scoreboard #(.NREG(NREG), .NRD(NRD), .IDXW(IDXW)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .wb_fire   (wb_fire),
    .wb_group  (wb_group),
    .wb_index  (wb_index),
    .iss_valid (iss_valid),
    .iss_we    (iss_we),
    .iss_group (iss_group),
    .iss_index (iss_index),
    .rs_group  (rs_group),
    .rs_index  (rs_index),
    .iss_ready (iss_ready),
    .rs_busy   (sb_busy),
    .sb_err    (sb_err)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [1:0]      g;
    logic [IDXW-1:0] i;
    logic            hit;
    assign g = rs_group[port_lsb(p, 2) +: 2];
    assign i = rs_index[port_lsb(p, IDXW) +: IDXW];
`ifdef WB_BYPASS_EN
    assign hit = wb_fire && (g == wb_group) && (i == wb_index);
`else
    assign hit = 1'b0;
`endif
    assign rs_busy[p] = sb_busy[p] && !hit;
    assign dout_r[port_lsb(p, XLEN) +: XLEN] =
      (g == REG_GROUP_R && i != '0) ? (hit ? wb_data_r : bank_r[i]) : '0;
    assign dout_f[port_lsb(p, XLEN) +: XLEN] =
      (g == REG_GROUP_F) ? (hit ? wb_data_f : bank_f[i]) : '0;
    assign dout_m[port_lsb(p, MLEN) +: MLEN] =
      (g == REG_GROUP_M) ? (hit ? wb_data_m : bank_m[i]) : '0;
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Bench for wb_regfile_sb: reference model of banks/busy/error plus directed literal scenarios and random traffic.
module tb_wb_regfile_sb;

  localparam int XLEN = 32, MLEN = 512, NREG = 32, NRD = 3, IDXW = 5;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b0;
  logic                wb_valid = 1'b0, wb_ready;
  logic [1:0]          wb_group = '0;
  logic [IDXW-1:0]     wb_index = '0;
  logic [XLEN-1:0]     wb_data_r = '0, wb_data_f = '0;
  logic [MLEN-1:0]     wb_data_m = '0;
  logic                iss_valid = 1'b0, iss_ready, iss_we = 1'b0;
  logic [1:0]          iss_group = '0;
  logic [IDXW-1:0]     iss_index = '0;
  logic [2*NRD-1:0]    rs_group = '0;
  logic [IDXW*NRD-1:0] rs_index = '0;
  logic [NRD-1:0]      rs_busy;
  logic [XLEN*NRD-1:0] dout_r, dout_f;
  logic [MLEN*NRD-1:0] dout_m;
  logic                init_done, sb_err;

  wb_regfile_sb #(.XLEN(XLEN), .MLEN(MLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_group(wb_group),
    .wb_index(wb_index), .wb_data_r(wb_data_r), .wb_data_f(wb_data_f), .wb_data_m(wb_data_m),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_we(iss_we), .iss_group(iss_group),
    .iss_index(iss_index), .rs_group(rs_group), .rs_index(rs_index), .rs_busy(rs_busy),
    .dout_r(dout_r), .dout_f(dout_f), .dout_m(dout_m), .init_done(init_done), .sb_err(sb_err)
  );

  int vectors = 0, miscompares = 0;

  // Reference model state
  logic [XLEN-1:0] mr [NREG];
  logic [XLEN-1:0] mf [NREG];
  logic [MLEN-1:0] mm [NREG];
  bit              mbusy [4][NREG];
  bit              merr;
  int              mcyc;

  task automatic chk(input string name, input logic [MLEN-1:0] act, input logic [MLEN-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic bit tracked(input logic [1:0] g, input logic [IDXW-1:0] i);
    return (g != 2'b11) && !(g == 2'b00 && i == 0);
  endfunction

  function automatic bit m_run();
    return rst && (mcyc >= NREG);
  endfunction

  function automatic bit m_iss_ready();
    bit commit_same;
    commit_same = m_run() && wb_valid && wb_group == iss_group && wb_index == iss_index;
    return m_run() && !(iss_we && mbusy[iss_group][iss_index] && !commit_same);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) begin
      mr[k] = '0; mf[k] = '0; mm[k] = '0;
      for (int g = 0; g < 4; g++) mbusy[g][k] = 1'b0;
    end
    merr = 1'b0;
    mcyc = 0;
  endtask

  task automatic model_check();
    bit run, hit;
    logic [1:0] g;
    logic [IDXW-1:0] i;
    run = m_run();
    chk("wb_ready", wb_ready, run);
    chk("init_done", init_done, run);
    chk("iss_ready", iss_ready, m_iss_ready());
    chk("sb_err", sb_err, merr);
    for (int p = 0; p < NRD; p++) begin
      g = rs_group[2*p +: 2];
      i = rs_index[IDXW*p +: IDXW];
      hit = BYP && run && wb_valid && g == wb_group && i == wb_index;
      chk($sformatf("rs_busy[%0d]", p), rs_busy[p], mbusy[g][i] && !hit);
      if (run) begin
        chk($sformatf("dout_r[%0d]", p), dout_r[XLEN*p +: XLEN],
            (g == 2'b00 && i != 0) ? (hit ? wb_data_r : mr[i]) : '0);
        chk($sformatf("dout_f[%0d]", p), dout_f[XLEN*p +: XLEN],
            (g == 2'b01) ? (hit ? wb_data_f : mf[i]) : '0);
        chk($sformatf("dout_m[%0d]", p), dout_m[MLEN*p +: MLEN],
            (g == 2'b10) ? (hit ? wb_data_m : mm[i]) : '0);
      end
    end
  endtask

  task automatic model_update();
    bit run, irdy;
    run  = m_run();
    irdy = m_iss_ready();
    if (run && wb_valid) begin
      if (tracked(wb_group, wb_index)) begin
        if (!mbusy[wb_group][wb_index]) merr = 1'b1;
        mbusy[wb_group][wb_index] = 1'b0;
      end
      case (wb_group)
        2'b00: if (wb_index != 0) mr[wb_index] = wb_data_r;
        2'b01: mf[wb_index] = wb_data_f;
        2'b10: mm[wb_index] = wb_data_m;
        default: ;
      endcase
    end
    if (run && iss_valid && irdy && iss_we && tracked(iss_group, iss_index))
      mbusy[iss_group][iss_index] = 1'b1;
    if (rst) mcyc++;
  endtask

  task automatic half();
    @(negedge clk);
    model_check();
  endtask

  task automatic fin();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0;
    iss_valid = 1'b0;
    iss_we = 1'b0;
  endtask

  task automatic set_rs(input int p, input logic [1:0] g, input logic [IDXW-1:0] i);
    rs_group[2*p +: 2] = g;
    rs_index[IDXW*p +: IDXW] = i;
  endtask

  task automatic commit(input logic [1:0] g, input logic [IDXW-1:0] i, input logic [MLEN-1:0] d);
    wb_valid = 1'b1; wb_group = g; wb_index = i;
    wb_data_r = d[XLEN-1:0]; wb_data_f = d[XLEN-1:0]; wb_data_m = d;
  endtask

  task automatic issue(input logic [1:0] g, input logic [IDXW-1:0] i);
    iss_valid = 1'b1; iss_we = 1'b1; iss_group = g; iss_index = i;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    half();
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_iss_ready", iss_ready, 1'b0);
    fin();
    rst = 1'b1;
  endtask

  task automatic count_init(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      half();
      if (init_done) break;
      fin();
      n++;
    end
    chk(name, n, NREG);
    fin();
  endtask

  function automatic logic [MLEN-1:0] rnd_m();
    logic [MLEN-1:0] v;
    for (int k = 0; k < MLEN/32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  logic [MLEN-1:0] pat, ones;

  initial begin
    ones = '1;
    @(posedge clk); #1;

    // Power-up sweep: exactly NREG cycles, then reads are zero
    do_reset();
    set_rs(0, 2'b00, 5'd7); set_rs(1, 2'b01, 5'd9); set_rs(2, 2'b10, 5'd31);
    iss_valid = 1'b1; iss_we = 1'b1; wb_valid = 1'b1;
    count_init("init_cycles");
    idle();
    half();
    chk("zero_r", dout_r[XLEN-1:0], 0);
    chk("zero_m", dout_m[MLEN*2 +: MLEN], 0);
    fin();

    // Issue R5, then commit DEADBEEF
    set_rs(0, 2'b00, 5'd5);
    issue(2'b00, 5'd5);
    half(); chk("r5_iss_ready", iss_ready, 1'b1); chk("r5_busy_pre", rs_busy[0], 1'b0); fin();
    idle();
    half(); chk("r5_busy", rs_busy[0], 1'b1); fin();
    commit(2'b00, 5'd5, 512'hDEADBEEF);
    half();
    chk("r5_busy_commit", rs_busy[0], !BYP);
    chk("r5_dout_commit", dout_r[XLEN-1:0], BYP ? 32'hDEADBEEF : 32'h0);
    fin();
    idle();
    half();
    chk("r5_dout", dout_r[XLEN-1:0], 32'hDEADBEEF);
    chk("r5_busy_post", rs_busy[0], 1'b0);
    chk("r5_sb_err", sb_err, 1'b0);
    fin();

    // WAW stall on F3, released by a same-cycle commit; set wins
    set_rs(1, 2'b01, 5'd3);
    issue(2'b01, 5'd3);
    half(); fin();
    half(); chk("f3_stall", iss_ready, 1'b0); fin();
    commit(2'b01, 5'd3, 512'hF00D);
    half(); chk("f3_release", iss_ready, 1'b1); fin();
    idle();
    half(); chk("f3_still_busy", rs_busy[1], 1'b1); chk("f3_sb_err", sb_err, 1'b0); fin();
    commit(2'b01, 5'd3, 512'hBEEF);
    half(); fin();
    idle();

    // R0 drop, M7 unissued commit
    set_rs(0, 2'b00, 5'd0);
    commit(2'b00, 5'd0, 512'h1234);
    half(); fin();
    idle();
    half(); chk("r0_zero", dout_r[XLEN-1:0], 0); chk("r0_no_err", sb_err, 1'b0); fin();
    pat = rnd_m();
    set_rs(2, 2'b10, 5'd7);
    commit(2'b10, 5'd7, pat);
    half(); fin();
    idle();
    half(); chk("m7_err", sb_err, 1'b1); chk("m7_data", dout_m[MLEN*2 +: MLEN], pat); fin();
    half(); chk("m7_err_sticky", sb_err, 1'b1); fin();

    // Forwarding of M2 during its commit
    set_rs(2, 2'b10, 5'd2);
    commit(2'b10, 5'd2, ones);
    half(); chk("m2_bypass", dout_m[MLEN*2 +: MLEN], BYP ? ones : '0); fin();
    idle();
    half(); chk("m2_written", dout_m[MLEN*2 +: MLEN], ones); fin();

    // Reset mid-sweep at cnt=10
    do_reset();
    for (int k = 0; k < 10; k++) begin half(); fin(); end
    do_reset();
    count_init("init_cycles_restart");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_group  = 2'($urandom_range(0, 3));
      wb_index  = ($urandom_range(0, 3) == 0) ? IDXW'($urandom) : IDXW'($urandom_range(0, 7));
      wb_data_r = $urandom; wb_data_f = $urandom; wb_data_m = rnd_m();
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_we    = ($urandom_range(0, 3) != 0);
      iss_group = 2'($urandom_range(0, 3));
      iss_index = IDXW'($urandom_range(0, 7));
      for (int p = 0; p < NRD; p++) set_rs(p, 2'($urandom_range(0, 3)), IDXW'($urandom_range(0, 7)));
      half(); fin();
    end
    idle();

    // Reset in RUN with R9 busy
    set_rs(0, 2'b00, 5'd9);
    wb_valid = 1'b0;
    issue(2'b00, 5'd9);
    iss_we = 1'b1;
    half(); fin();
    idle();
    half(); chk("r9_busy", rs_busy[0], 1'b1); fin();
    rst = 1'b0;
    model_reset();
    half();
    chk("run_rst_busy", rs_busy[0], 1'b0);
    chk("run_rst_ready", wb_ready, 1'b0);
    chk("run_rst_err", sb_err, 1'b0);
    fin();
    rst = 1'b1;
    count_init("init_cycles_run_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
